// File: rtl/addr_seq_if.sv
// ---------------------------------------------------------------------------
// addr_seq_if
// Bus bundle between an instruction-level controller (master) and the
// addr_seq operand address sequencer (slave).
//
// Master -> slave : start, mode, store, pc, x, y, d_in, wdata
// Slave -> master : addr, d_out, write, pc_inc, ea, busy, done
//
// Parameters:
//   ADDR_W : address bus width (9..16)
//   DATA_W : data bus width (8 only)
// ---------------------------------------------------------------------------
interface addr_seq_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              start;
    logic [2:0]        mode;
    logic              store;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] y;
    logic [DATA_W-1:0] d_in;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] d_out;
    logic              write;
    logic              pc_inc;
    logic [ADDR_W-1:0] ea;
    logic              busy;
    logic              done;

    // The controller side drives requests, operands and read data.
    modport master (
        output start, mode, store, pc, x, y, d_in, wdata,
        input  addr, d_out, write, pc_inc, ea, busy, done
    );

    // The sequencer side consumes requests and drives the memory bus.
    modport slave (
        input  start, mode, store, pc, x, y, d_in, wdata,
        output addr, d_out, write, pc_inc, ea, busy, done
    );
endinterface

// File: rtl/addr_seq.sv
// ---------------------------------------------------------------------------
// addr_seq
// Operand address sequencer for a 6502-style addressing unit. On start it
// fetches operand bytes from pc, optionally walks a zero-page pointer, forms
// the effective address and performs the final access in EXEC.
//
// Ports:
//   clk  : single clock, all state changes on its rising edge
//   rst  : asynchronous, active-low reset
//   bus  : addr_seq_if.slave
//          in : start, mode (0 IMM,1 ZP,2 ZPX,3 ABS,4 ABSX,5 ABSY,6 INX,7 INY),
//               store, pc, x, y, d_in, wdata
//          out: addr, d_out, write, pc_inc, ea, busy, done
//
// Parameters:
//   ADDR_W : address width, 9..16
//   DATA_W : data width, only 8 supported
//
// Build option:
//   ADDR_SEQ_PAGE_PENALTY_EN : when defined, indexed modes whose low-byte
//   add carries spend an extra FIX cycle doing a dummy read at
//   {base_hi, low sum}. When undefined FIX is never entered.
// ---------------------------------------------------------------------------
module addr_seq #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    addr_seq_if.slave  bus
);

    localparam int PAD_W = ADDR_W - DATA_W;
    localparam logic [DATA_W-1:0] ONE_BYTE = {{(DATA_W-1){1'b0}}, 1'b1};

`ifdef ADDR_SEQ_PAGE_PENALTY_EN
    localparam bit PAGE_PENALTY = 1'b1;
`else
    localparam bit PAGE_PENALTY = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_OPL,
        S_OPH,
        S_PTRL,
        S_PTRH,
        S_FIX,
        S_EXEC
    } state_t;

    typedef enum logic [2:0] {
        M_IMM,
        M_ZP,
        M_ZPX,
        M_ABS,
        M_ABSX,
        M_ABSY,
        M_INX,
        M_INY
    } mode_t;

    state_t              r_state;
    mode_t               r_mode;
    logic                r_store;
    logic [DATA_W-1:0]   r_x;
    logic [DATA_W-1:0]   r_y;
    logic [DATA_W-1:0]   r_op;
    logic [DATA_W-1:0]   r_ptrLo;
    logic [ADDR_W-1:0]   r_ea;
    logic [ADDR_W-1:0]   r_fixAddr;
    logic                r_busy;
    logic                r_done;
    logic                r_write;
    logic                r_pcInc;

    state_t              w_next;
    logic                w_accept;
    mode_t               w_modeIn;
    mode_t               w_modeNext;
    logic                w_storeNext;
    logic [DATA_W-1:0]   w_idx;
    logic [DATA_W-1:0]   w_lowBase;
    logic [DATA_W:0]     w_lowSum;
    logic                w_carry;
    logic [DATA_W-1:0]   w_ptrByte;
    logic [DATA_W-1:0]   w_ptrByteNext;
    logic [ADDR_W-1:0]   w_indexedEa;
    logic [ADDR_W-1:0]   w_fixAddr;
    logic [ADDR_W-1:0]   w_addr;

    // {hi, lo} with hi truncated to the bits that fit in ADDR_W.
    function automatic logic [ADDR_W-1:0] joinAddr(input logic [DATA_W-1:0] hi,
                                                   input logic [DATA_W-1:0] lo);
        logic [2*DATA_W-1:0] full;
        full = {hi, lo};
        return full[ADDR_W-1:0];
    endfunction

    function automatic logic [ADDR_W-1:0] zeroPage(input logic [DATA_W-1:0] b);
        return {{PAD_W{1'b0}}, b};
    endfunction

    function automatic state_t firstState(input mode_t m);
        return (m == M_IMM) ? S_EXEC : S_OPL;
    endfunction

    // Start is only honoured at the boundary between sequences (IDLE or the
    // final EXEC cycle). The "next" mode/store let the registered output flags
    // be computed for a sequence that begins at this very edge.
    always_comb begin
        w_modeIn    = mode_t'(bus.mode);
        w_accept    = bus.start && ((r_state == S_IDLE) || (r_state == S_EXEC));
        w_modeNext  = w_accept ? w_modeIn : r_mode;
        w_storeNext = w_accept ? bus.store : r_store;
    end

    // Indexed address arithmetic. In OPH the base low byte is the first
    // operand; in PTRH it is the pointer low byte. The high byte is always
    // arriving on d_in in that same cycle.
    always_comb begin
        w_idx         = (r_mode == M_ABSX) ? r_x : r_y;
        w_lowBase     = (r_state == S_PTRH) ? r_ptrLo : r_op;
        w_lowSum      = {1'b0, w_lowBase} + {1'b0, w_idx};
        w_carry       = w_lowSum[DATA_W];
        w_ptrByte     = (r_mode == M_INX) ? (r_op + r_x) : r_op;
        w_ptrByteNext = w_ptrByte + ONE_BYTE;
        w_indexedEa   = joinAddr(bus.d_in, w_lowBase) + {{PAD_W{1'b0}}, w_idx};
        w_fixAddr     = joinAddr(bus.d_in, w_lowSum[DATA_W-1:0]);
    end

    // Next-state decision. FIX is only reachable when the page-penalty build
    // option is on and the indexed low-byte add crossed a page.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = firstState(w_modeIn);
                end
            end
            S_OPL: begin
                case (r_mode)
                    M_ABS, M_ABSX, M_ABSY: w_next = S_OPH;
                    M_INX, M_INY:          w_next = S_PTRL;
                    default:               w_next = S_EXEC;
                endcase
            end
            S_OPH: begin
                if (((r_mode == M_ABSX) || (r_mode == M_ABSY)) && w_carry && PAGE_PENALTY) begin
                    w_next = S_FIX;
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_PTRL: begin
                w_next = S_PTRH;
            end
            S_PTRH: begin
                if ((r_mode == M_INY) && w_carry && PAGE_PENALTY) begin
                    w_next = S_FIX;
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_FIX: begin
                w_next = S_EXEC;
            end
            S_EXEC: begin
                w_next = w_accept ? firstState(w_modeIn) : S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Memory address mux. While fetching operands (and idling) the bus shows
    // pc directly, because the external PC moves on the same edge pc_inc is
    // seen; everything else comes from registered addresses.
    always_comb begin
        w_addr = bus.pc;
        case (r_state)
            S_PTRL:  w_addr = zeroPage(w_ptrByte);
            S_PTRH:  w_addr = zeroPage(w_ptrByteNext);
            S_FIX:   w_addr = r_fixAddr;
            S_EXEC:  w_addr = r_ea;
            default: w_addr = bus.pc;
        endcase
    end

    // Sequencer state, latched request, captured bytes, effective address and
    // registered output flags. The IMM effective address is the pc that will
    // be current during EXEC, which is one past the present pc when this cycle
    // is itself incrementing it (a back-to-back IMM after IMM).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_mode    <= M_IMM;
            r_store   <= 1'b0;
            r_x       <= '0;
            r_y       <= '0;
            r_op      <= '0;
            r_ptrLo   <= '0;
            r_ea      <= '0;
            r_fixAddr <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_write   <= 1'b0;
            r_pcInc   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next == S_OPL) || (w_next == S_OPH) || (w_next == S_PTRL) ||
                       (w_next == S_PTRH) || (w_next == S_FIX);
            r_done  <= (w_next == S_EXEC);
            r_write <= (w_next == S_EXEC) && w_storeNext && (w_modeNext != M_IMM);
            r_pcInc <= (w_next == S_OPL) || (w_next == S_OPH) ||
                       ((w_next == S_EXEC) && (w_modeNext == M_IMM));

            if (w_accept) begin
                r_mode  <= w_modeIn;
                r_store <= bus.store;
                r_x     <= bus.x;
                r_y     <= bus.y;
                if (w_modeIn == M_IMM) begin
                    r_ea <= bus.pc + {{(ADDR_W-1){1'b0}}, r_pcInc};
                end
            end

            case (r_state)
                S_OPL: begin
                    r_op <= bus.d_in;
                    if (r_mode == M_ZP) begin
                        r_ea <= zeroPage(bus.d_in);
                    end else if (r_mode == M_ZPX) begin
                        r_ea <= zeroPage(bus.d_in + r_x);
                    end
                end
                S_OPH: begin
                    if (r_mode == M_ABS) begin
                        r_ea <= joinAddr(bus.d_in, r_op);
                    end else begin
                        r_ea      <= w_indexedEa;
                        r_fixAddr <= w_fixAddr;
                    end
                end
                S_PTRL: begin
                    r_ptrLo <= bus.d_in;
                end
                S_PTRH: begin
                    if (r_mode == M_INX) begin
                        r_ea <= joinAddr(bus.d_in, r_ptrLo);
                    end else begin
                        r_ea      <= w_indexedEa;
                        r_fixAddr <= w_fixAddr;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.addr   = w_addr;
    assign bus.ea     = r_ea;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.write  = r_write;
    assign bus.pc_inc = r_pcInc;
    assign bus.d_out  = r_write ? bus.wdata : '0;

endmodule

// File: tb/tb_addr_seq.sv
// ---------------------------------------------------------------------------
// tb_addr_seq
// Directed scoreboard bench for addr_seq. The stimulus process pushes the
// expected EXEC-cycle response whenever it issues a start; a monitor process
// pops and compares every time the sequencer pulses done. Intermediate
// cycles (operand fetch, pointer walk, FIX, reset) are checked inline.
// Honours ADDR_SEQ_PAGE_PENALTY_EN for the FIX cycle expectations.
// ---------------------------------------------------------------------------
module tb_addr_seq;

    localparam int ADDR_W = 16;
    localparam logic [2:0] IMM  = 3'd0;
    localparam logic [2:0] ZP   = 3'd1;
    localparam logic [2:0] ZPX  = 3'd2;
    localparam logic [2:0] ABS  = 3'd3;
    localparam logic [2:0] ABSX = 3'd4;
    localparam logic [2:0] INX  = 3'd6;
    localparam logic [2:0] INY  = 3'd7;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] ea;
        logic        write;
        logic [7:0]  dout;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] pcReg;
    int          checks = 0;
    int          failures = 0;
    exp_t        expQ[$];

    addr_seq_if #(.ADDR_W(ADDR_W), .DATA_W(8)) bus();

    addr_seq #(.ADDR_W(ADDR_W), .DATA_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // External program counter: restarts at 0x0200 on reset and steps on
    // every edge at which the sequencer asks for it.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcReg <= 16'h0200;
        end else if (bus.pc_inc) begin
            pcReg <= pcReg + 16'd1;
        end
    end
    assign bus.pc = pcReg;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic [2:0] m, input logic st,
                                 input logic [7:0] xv, input logic [7:0] yv,
                                 input logic [7:0] wd);
        bus.start = s;
        bus.mode  = m;
        bus.store = st;
        bus.x     = xv;
        bus.y     = yv;
        bus.wdata = wd;
        bus.d_in  = 8'h00;
    endtask

    task automatic feedByte(input logic [7:0] dv);
        bus.start = 1'b0;
        bus.d_in  = dv;
    endtask

    task automatic expectExec(input logic [15:0] a, input logic [15:0] e,
                              input logic w, input logic [7:0] d);
        exp_t item;
        item.addr  = a;
        item.ea    = e;
        item.write = w;
        item.dout  = d;
        expQ.push_back(item);
    endtask

    // Scoreboard monitor: every done pulse must match the oldest expectation.
    initial begin : monitor
        exp_t item;
        forever begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_done: got done=1 addr=0x%0h expected no done", bus.addr);
                end else begin
                    item = expQ.pop_front();
                    checkOutput("exec_addr",  32'(bus.addr),  32'(item.addr));
                    checkOutput("exec_ea",    32'(bus.ea),    32'(item.ea));
                    checkOutput("exec_write", 32'(bus.write), 32'(item.write));
                    checkOutput("exec_dout",  32'(bus.d_out), 32'(item.dout));
                end
            end
        end
    end

    // Watchdog so the run always ends even if the clock process misbehaves.
    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected end of stimulus");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus with hand-computed expectations.
    initial begin : stimulus
        applyStimulus(1'b0, IMM, 1'b0, 8'h00, 8'h00, 8'h00);

        // Reset values while rst is held low.
        repeat (2) @(negedge clk);
        checkOutput("rst_busy",   32'(bus.busy),   32'd0);
        checkOutput("rst_done",   32'(bus.done),   32'd0);
        checkOutput("rst_write",  32'(bus.write),  32'd0);
        checkOutput("rst_pcinc",  32'(bus.pc_inc), 32'd0);
        checkOutput("rst_ea",     32'(bus.ea),     32'd0);
        checkOutput("rst_dout",   32'(bus.d_out),  32'd0);
        checkOutput("rst_addr",   32'(bus.addr),   32'h0200);

        // ZP, start on the first edge after reset release.
        #1 rst = 1'b1;
        applyStimulus(1'b1, ZP, 1'b0, 8'h00, 8'h00, 8'h00);
        expectExec(16'h0042, 16'h0042, 1'b0, 8'h00);
        @(negedge clk);
        checkOutput("zp_opl_busy",  32'(bus.busy),   32'd1);
        checkOutput("zp_opl_addr",  32'(bus.addr),   32'h0200);
        checkOutput("zp_opl_pcinc", 32'(bus.pc_inc), 32'd1);
        #1 feedByte(8'h42);
        @(negedge clk);
        checkOutput("zp_exec_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        checkOutput("idle_addr",  32'(bus.addr),   32'h0201);
        checkOutput("idle_pcinc", 32'(bus.pc_inc), 32'd0);
        checkOutput("idle_done",  32'(bus.done),   32'd0);

        // ABSX with a page crossing: 0x12F8 + 0x10.
        #1 applyStimulus(1'b1, ABSX, 1'b0, 8'h10, 8'h00, 8'h00);
        expectExec(16'h1308, 16'h1308, 1'b0, 8'h00);
        @(negedge clk);
        checkOutput("absx_opl_addr", 32'(bus.addr), 32'h0201);
        #1 feedByte(8'hF8);
        @(negedge clk);
        checkOutput("absx_oph_addr",  32'(bus.addr),   32'h0202);
        checkOutput("absx_oph_pcinc", 32'(bus.pc_inc), 32'd1);
        #1 feedByte(8'h12);
`ifdef ADDR_SEQ_PAGE_PENALTY_EN
        @(negedge clk);
        checkOutput("absx_fix_addr",  32'(bus.addr),  32'h1208);
        checkOutput("absx_fix_busy",  32'(bus.busy),  32'd1);
        checkOutput("absx_fix_write", 32'(bus.write), 32'd0);
        checkOutput("absx_fix_ea",    32'(bus.ea),    32'h1308);
        #1 feedByte(8'h00);
`endif
        @(negedge clk);
        checkOutput("absx_exec_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);

        // INX with zero-page pointer wrap: (0xFF + 0x01) -> 0x00 / 0x01.
        #1 applyStimulus(1'b1, INX, 1'b0, 8'h01, 8'h00, 8'h00);
        expectExec(16'h1234, 16'h1234, 1'b0, 8'h00);
        @(negedge clk);
        checkOutput("inx_opl_addr", 32'(bus.addr), 32'h0203);
        #1 feedByte(8'hFF);
        @(negedge clk);
        checkOutput("inx_ptrl_addr",  32'(bus.addr),   32'h0000);
        checkOutput("inx_ptrl_pcinc", 32'(bus.pc_inc), 32'd0);
        checkOutput("inx_ptrl_busy",  32'(bus.busy),   32'd1);
        #1 feedByte(8'h34);
        @(negedge clk);
        checkOutput("inx_ptrh_addr", 32'(bus.addr), 32'h0001);
        #1 feedByte(8'h12);
        @(negedge clk);
        @(negedge clk);

        // INY with pointer wrap 0xFF -> 0x00, no low-byte carry.
        #1 applyStimulus(1'b1, INY, 1'b0, 8'h00, 8'h05, 8'h00);
        expectExec(16'h3005, 16'h3005, 1'b0, 8'h00);
        @(negedge clk);
        checkOutput("iny_opl_addr", 32'(bus.addr), 32'h0204);
        #1 feedByte(8'hFF);
        @(negedge clk);
        checkOutput("iny_ptrl_addr", 32'(bus.addr), 32'h00FF);
        #1 feedByte(8'h00);
        @(negedge clk);
        checkOutput("iny_ptrh_addr", 32'(bus.addr), 32'h0000);
        #1 feedByte(8'h30);
        @(negedge clk);
        checkOutput("iny_exec_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);

        // ABS store, then back-to-back ZP started from EXEC.
        #1 applyStimulus(1'b1, ABS, 1'b1, 8'h00, 8'h00, 8'hA5);
        expectExec(16'h0300, 16'h0300, 1'b1, 8'hA5);
        @(negedge clk);
        checkOutput("abs_opl_addr",  32'(bus.addr),  32'h0205);
        checkOutput("abs_opl_write", 32'(bus.write), 32'd0);
        checkOutput("abs_opl_dout",  32'(bus.d_out), 32'd0);
        #1 feedByte(8'h00);
        @(negedge clk);
        checkOutput("abs_oph_addr",  32'(bus.addr),  32'h0206);
        checkOutput("abs_oph_write", 32'(bus.write), 32'd0);
        #1 feedByte(8'h03);
        @(negedge clk);
        #1 applyStimulus(1'b1, ZP, 1'b0, 8'h00, 8'h00, 8'h00);
        expectExec(16'h0077, 16'h0077, 1'b0, 8'h00);
        @(negedge clk);
        checkOutput("b2b_opl_busy",  32'(bus.busy),  32'd1);
        checkOutput("b2b_opl_addr",  32'(bus.addr),  32'h0207);
        checkOutput("b2b_opl_write", 32'(bus.write), 32'd0);
        #1 feedByte(8'h77);
        @(negedge clk);
        @(negedge clk);

        // ZPX wrap (0xF0 + 0x20 -> 0x10), then IMM store (write forced low)
        // from EXEC, then IMM again from the IMM EXEC cycle.
        #1 applyStimulus(1'b1, ZPX, 1'b0, 8'h20, 8'h00, 8'h00);
        expectExec(16'h0010, 16'h0010, 1'b0, 8'h00);
        @(negedge clk);
        checkOutput("zpx_opl_addr", 32'(bus.addr), 32'h0208);
        #1 feedByte(8'hF0);
        @(negedge clk);
        checkOutput("zpx_exec_pcinc", 32'(bus.pc_inc), 32'd0);
        #1 applyStimulus(1'b1, IMM, 1'b1, 8'h00, 8'h00, 8'h5A);
        expectExec(16'h0209, 16'h0209, 1'b0, 8'h00);
        @(negedge clk);
        checkOutput("imm_exec_pcinc", 32'(bus.pc_inc), 32'd1);
        checkOutput("imm_exec_busy",  32'(bus.busy),   32'd0);
        #1 applyStimulus(1'b1, IMM, 1'b0, 8'h00, 8'h00, 8'h00);
        expectExec(16'h020A, 16'h020A, 1'b0, 8'h00);
        @(negedge clk);
        checkOutput("imm2_exec_pcinc", 32'(bus.pc_inc), 32'd1);
        #1 applyStimulus(1'b0, IMM, 1'b0, 8'h00, 8'h00, 8'h00);
        @(negedge clk);
        checkOutput("imm_idle_addr",  32'(bus.addr),   32'h020B);
        checkOutput("imm_idle_pcinc", 32'(bus.pc_inc), 32'd0);

        // Reset during OPH aborts the store with no EXEC.
        #1 applyStimulus(1'b1, ABS, 1'b1, 8'h00, 8'h00, 8'hC3);
        @(negedge clk);
        #1 feedByte(8'h11);
        @(negedge clk);
        checkOutput("abort_oph_busy", 32'(bus.busy), 32'd1);
        #1 rst = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        checkOutput("abort_busy",  32'(bus.busy),   32'd0);
        checkOutput("abort_ea",    32'(bus.ea),     32'd0);
        checkOutput("abort_done",  32'(bus.done),   32'd0);
        checkOutput("abort_write", 32'(bus.write),  32'd0);
        checkOutput("abort_pcinc", 32'(bus.pc_inc), 32'd0);
        checkOutput("abort_addr",  32'(bus.addr),   32'h0200);
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("post_abort_busy",  32'(bus.busy),  32'd0);
        checkOutput("post_abort_write", 32'(bus.write), 32'd0);

        checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
